// File: rtl/linebuf_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
// Shared constants and helpers for the line-buffer ring controller.
//   DEF_AWIDTH / DEF_NLINES / DEF_RWIDTH : default parameter values
//   BRD_TOP / BRD_BOT / BRD_LEFT / BRD_RIGHT : bit indices into the 4-bit
//                                              border vector {top,bot,left,right}
//   sel_inc() : modulo-n increment for line-select fields
// -----------------------------------------------------------------------------
package linebuf_pkg;

    localparam int DEF_AWIDTH = 11;
    localparam int DEF_NLINES = 3;
    localparam int DEF_RWIDTH = 11;

    localparam int BRD_TOP   = 3;
    localparam int BRD_BOT   = 2;
    localparam int BRD_LEFT  = 1;
    localparam int BRD_RIGHT = 0;

    // Next line index in a ring of n lines.
    function automatic int unsigned sel_inc(input int unsigned sel, input int unsigned n);
        return (sel + 1 >= n) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/linebuf_ring_ptr.sv
// -----------------------------------------------------------------------------
// linebuf_ring_ptr
// Rotating write-line pointer for a ring of NLINES line SRAMs, plus the count
// of completely buffered lines (saturating at NLINES-1).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   advance    in   pixel beat; state only moves on a beat
//   restart    in   start-of-frame beat; pointer and fill read as zero
//   wrap       in   this beat is the last column of the line
//   sel        out  effective line being written on this beat
//   next_sel   out  sel + 1 mod NLINES (oldest buffered line after this beat)
//   fill_any   out  effective fill >= 1 (at least one line buffered)
//   fill_full  out  effective fill == NLINES-1 (window complete)
// -----------------------------------------------------------------------------
module linebuf_ring_ptr
    import linebuf_pkg::*;
#(
    parameter int NLINES = DEF_NLINES,
    parameter int SWIDTH = $clog2(NLINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              restart,
    input  logic              wrap,
    output logic [SWIDTH-1:0] sel,
    output logic [SWIDTH-1:0] next_sel,
    output logic              fill_any,
    output logic              fill_full
);

    logic [SWIDTH-1:0] sel_q;
    logic [SWIDTH-1:0] fill_q;
    logic [SWIDTH-1:0] fill_eff;

    // A start-of-frame beat behaves as if the registers were already cleared.
    assign sel      = restart ? '0 : sel_q;
    assign fill_eff = restart ? '0 : fill_q;

    assign next_sel  = SWIDTH'(sel_inc(32'(sel), 32'(NLINES)));
    assign fill_any  = (fill_eff != '0);
    assign fill_full = (fill_eff == SWIDTH'(NLINES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q  <= '0;
            fill_q <= '0;
        end else if (advance) begin
            if (wrap) begin
                sel_q  <= next_sel;
                fill_q <= fill_full ? fill_eff : fill_eff + SWIDTH'(1);
            end else begin
                sel_q  <= sel;
                fill_q <= fill_eff;
            end
        end
    end

endmodule

// File: rtl/linebuf_ring_ctrl.sv
// -----------------------------------------------------------------------------
// linebuf_ring_ctrl
// Address / enable controller for a ring of NLINES single-port line SRAMs.
// One line is written per row while the others are read out at the same
// column, giving an NLINES-tall window once NLINES-1 lines are buffered.
//
// Optional feature macro: LINEBUF_BORDER_EN
//   defined   : border flags {top, bottom(=0), left, right} are computed from
//               the beat position and registered alongside valid
//   undefined : border is tied to zero
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   clken    in   pixel beat valid
//   sof      in   start of frame, qualifies the beat it coincides with
//   width    in   active line width in pixels (>= 2)
//   wr_en    out  per-SRAM write enable, active-low, combinational
//   rd_en    out  shared read enable, active-low, combinational
//   wr_addr  out  write address (column)
//   rd_addr  out  read address (same column)
//   wr_sel   out  line being written
//   rd_sel   out  oldest buffered line, registered with valid
//   row      out  row index within the frame, saturating
//   eol      out  pulse one cycle after the last-column beat
//   valid    out  SRAM window data valid this cycle
//   border   out  window border flags, registered with valid
// -----------------------------------------------------------------------------
module linebuf_ring_ctrl
    import linebuf_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int NLINES = DEF_NLINES,
    parameter int SWIDTH = $clog2(NLINES),
    parameter int RWIDTH = DEF_RWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              sof,
    input  logic [AWIDTH-1:0] width,
    output logic [NLINES-1:0] wr_en,
    output logic              rd_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [AWIDTH-1:0] rd_addr,
    output logic [SWIDTH-1:0] wr_sel,
    output logic [SWIDTH-1:0] rd_sel,
    output logic [RWIDTH-1:0] row,
    output logic              eol,
    output logic              valid,
    output logic [3:0]        border
);

    logic              beat;
    logic              restart;
    logic              wrap;
    logic [AWIDTH-1:0] col_q;
    logic [AWIDTH-1:0] col_eff;
    logic [RWIDTH-1:0] row_q;
    logic [RWIDTH-1:0] row_eff;
    logic [SWIDTH-1:0] sel_eff;
    logic [SWIDTH-1:0] rd_next;
    logic              fill_any;
    logic              fill_full;

    assign beat    = clken;
    assign restart = clken && sof;

    // On a start-of-frame beat the position reads as zero so that beat is
    // written to column 0 of line 0.
    assign col_eff = restart ? '0 : col_q;
    assign row_eff = restart ? '0 : row_q;

    // >= rather than == so a width that shrinks below the current column
    // wraps on the next beat instead of running to the end of the address space.
    assign wrap = beat && (col_eff >= width - AWIDTH'(1));

    linebuf_ring_ptr #(
        .NLINES (NLINES),
        .SWIDTH (SWIDTH)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .advance   (beat),
        .restart   (restart),
        .wrap      (wrap),
        .sel       (sel_eff),
        .next_sel  (rd_next),
        .fill_any  (fill_any),
        .fill_full (fill_full)
    );

    // NOTE: every combinational output gets its default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_en = '1;
        for (int i = 0; i < NLINES; i++) begin
            if (beat && (sel_eff == SWIDTH'(i))) begin
                wr_en[i] = 1'b0;
            end
        end
    end

    assign rd_en   = !(beat && fill_any);
    assign wr_addr = col_eff;
    assign rd_addr = col_eff;
    assign wr_sel  = sel_eff;
    assign row     = row_eff;

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            eol    <= 1'b0;
            valid  <= 1'b0;
            rd_sel <= '0;
        end else begin
            // SRAM read data returns one cycle after rd_en, so valid is a
            // one-cycle pulse per qualifying beat rather than a held level.
            eol   <= wrap;
            valid <= beat && fill_full;
            if (beat) begin
                rd_sel <= rd_next;
                if (wrap) begin
                    col_q <= '0;
                    row_q <= (row_eff == '1) ? row_eff : row_eff + RWIDTH'(1);
                end else begin
                    col_q <= col_eff + AWIDTH'(1);
                    row_q <= row_eff;
                end
            end
        end
    end

`ifdef LINEBUF_BORDER_EN
    logic [3:0] border_d;
    logic [3:0] border_q;

    always_comb begin
        border_d = '0;
        if (beat && fill_full) begin
            // Fill completes on row NLINES-1, which is the first valid row.
            border_d[BRD_TOP]   = (row_eff == RWIDTH'(NLINES - 1));
            border_d[BRD_BOT]   = 1'b0;
            border_d[BRD_LEFT]  = (col_eff == '0);
            border_d[BRD_RIGHT] = (col_eff == width - AWIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            border_q <= '0;
        end else begin
            border_q <= border_d;
        end
    end

    assign border = border_q;
`else
    assign border = 4'b0;
`endif

endmodule

// File: tb/tb_linebuf_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_linebuf_ring_ctrl
// Self-checking bench for linebuf_ring_ctrl. The reference model tracks the
// column and the number of completed lines since frame start; line select,
// fill and row are derived from that count arithmetically.
// Honours LINEBUF_BORDER_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_linebuf_ring_ctrl;

    localparam int AW      = 11;
    localparam int NL      = 3;
    localparam int SW      = $clog2(NL);
    localparam int RW      = 11;
    localparam int ROW_MAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clken;
    logic          sof;
    logic [AW-1:0] width;
    logic [NL-1:0] wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] wr_sel;
    logic [SW-1:0] rd_sel;
    logic [RW-1:0] row;
    logic          eol;
    logic          valid;
    logic [3:0]    border;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_col    = 0;
    int m_lines  = 0;
    int m_rd_sel = 0;

    linebuf_ring_ctrl #(
        .AWIDTH (AW),
        .NLINES (NL),
        .SWIDTH (SW),
        .RWIDTH (RW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clken   (clken),
        .sof     (sof),
        .width   (width),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_sel  (wr_sel),
        .rd_sel  (rd_sel),
        .row     (row),
        .eol     (eol),
        .valid   (valid),
        .border  (border)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b0;
        clken = 1'b0;
        sof   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wr_en",   32'(wr_en),   32'({NL{1'b1}}));
        check("rst_rd_en",   32'(rd_en),   32'd1);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_sel",  32'(wr_sel),  32'd0);
        check("rst_rd_sel",  32'(rd_sel),  32'd0);
        check("rst_row",     32'(row),     32'd0);
        check("rst_eol",     32'(eol),     32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_border",  32'(border),  32'd0);
        @(negedge clk);
        rst      = 1'b1;
        m_col    = 0;
        m_lines  = 0;
        m_rd_sel = 0;
    endtask

    // One clock cycle: drive inputs, check the combinational outputs against
    // the model, advance the model, then check the registered outputs.
    task automatic step(input logic ce, input logic so);
        logic [NL-1:0] e_wr_en;
        logic [3:0]    e_border;
        int            sel_e;
        int            fill_e;
        int            row_e;
        logic          e_valid;
        logic          e_eol;

        @(negedge clk);
        clken = ce;
        sof   = so;
        #1;
        if (ce && so) begin
            m_col   = 0;
            m_lines = 0;
        end
        sel_e  = m_lines % NL;
        fill_e = (m_lines < NL - 1) ? m_lines : NL - 1;
        row_e  = (m_lines < ROW_MAX) ? m_lines : ROW_MAX;

        e_wr_en = '1;
        if (ce) e_wr_en[sel_e] = 1'b0;

        check("wr_en",   32'(wr_en),   32'(e_wr_en));
        check("rd_en",   32'(rd_en),   32'(!(ce && fill_e >= 1)));
        check("wr_addr", 32'(wr_addr), 32'(m_col));
        check("rd_addr", 32'(rd_addr), 32'(m_col));
        check("wr_sel",  32'(wr_sel),  32'(sel_e));
        check("row",     32'(row),     32'(row_e));

        e_valid  = ce && (fill_e == NL - 1);
        e_eol    = ce && (m_col >= int'(width) - 1);
        e_border = 4'b0;
`ifdef LINEBUF_BORDER_EN
        if (e_valid) begin
            e_border = {row_e == NL - 1, 1'b0, m_col == 0, m_col == int'(width) - 1};
        end
`endif
        if (ce) m_rd_sel = (sel_e + 1) % NL;
        if (e_eol) begin
            m_col = 0;
            m_lines++;
        end else if (ce) begin
            m_col++;
        end

        @(posedge clk);
        #1;
        check("eol",    32'(eol),    32'(e_eol));
        check("valid",  32'(valid),  32'(e_valid));
        check("rd_sel", 32'(rd_sel), 32'(m_rd_sel));
        check("border", 32'(border), 32'(e_border));
    endtask

    initial begin
        rst   = 1'b0;
        clken = 1'b0;
        sof   = 1'b0;
        width = AW'(4);

        // continuous stream, width 4, three lines plus first valid row
        apply_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);

        // same stream with gaps every other cycle
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end

        // sof in the middle of line 1 restarts position and fill
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        // sof without clken must not restart
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // width shrinks from 8 to 4 while the column is at 6
        width = AW'(8);
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        width = AW'(4);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // reset in the middle of line 2, then resume from line 0 column 0
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

        // randomized beats, rare sof and occasional width changes
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63, 0) == 0) width = AW'($urandom_range(9, 2));
            step($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0);
        end

        // row saturation with the narrowest line
        width = AW'(2);
        step(1'b1, 1'b1);
        for (int i = 0; i < 2 * (ROW_MAX + 3); i++) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
